centroid_tracker: RTL and testbench
===================================

# centroid_tracker

Downstream stage of the centre-of-mass divider: consumes the one-per-frame centroid `(x, y)` pulse and produces a temporally smoothed, gated position for the overlay and game logic. It performs exponential moving average (EMA) filtering, multi-frame acquisition, coasting across dropped frames, and optional jump rejection. It runs in the pixel clock domain alongside the centroid stage.

## Interface
- `ALPHA_SHIFT`, 2: EMA weight = 2^-ALPHA_SHIFT; also the number of fractional bits in the accumulators (1..4).
- `ACQ_FRAMES`, 3: consecutive accepted samples required to enter TRACK (1..15).
- `COAST_FRAMES`, 8: missed frames tolerated before LOST (1..15).
- `MAX_JUMP`, 64: per-axis rejection threshold in pixels (used only with jump rejection).
- `clk_in` in 1: pixel clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `x_in` in 11: centroid x from centre-of-mass stage.
- `y_in` in 10: centroid y.
- `valid_in` in 1: single-cycle sample strobe, at most one per frame.
- `frame_in` in 1: single-cycle end-of-frame pulse from video timing.
- `x_out` out 11: filtered x.
- `y_out` out 10: filtered y.
- `valid_out` out 1: single-cycle strobe; the filtered position was updated.
- `tracking_out` out 1: high in TRACK or COAST.
- `state_out` out 2: current state encoding.

## Operation
- States: LOST=0, ACQUIRE=1, TRACK=2, COAST=3.
- Accumulators `acc_x` are 11+ALPHA_SHIFT bits and `acc_y` are 10+ALPHA_SHIFT bits, both unsigned.
- Update rule: `acc <= acc + ((in<<F) - acc) >>> F`, with the difference computed signed, one bit wider than `acc`.
- Output is `acc >> F`, truncated. The result cannot exceed the input range, so no saturation is needed.
- Accepted sample:
  - Without jump rejection, any `valid_in`.
  - With jump rejection, `|in - out| <= MAX_JUMP` on both axes.
  - In LOST, every sample is accepted.
- Behaviour by state:
  - **LOST, sample:** seed `acc = in<<F`; set `hit_cnt = 1`; go to ACQUIRE, or directly to TRACK if ACQ_FRAMES==1.
  - **ACQUIRE, accepted sample:** EMA update; `hit_cnt++`; go to TRACK when `hit_cnt` reaches ACQ_FRAMES.
  - **ACQUIRE, rejected sample:** reseed to the sample; set `hit_cnt = 1`.
  - **ACQUIRE, `frame_in` with no sample this frame:** go to LOST.
  - **TRACK, accepted sample:** EMA update; `valid_out` pulse; clear `miss_cnt`.
  - **TRACK, rejected sample:** ignored; counts as a miss.
  - **TRACK, `frame_in` with no accepted sample this frame:** `miss_cnt = 1`; go to COAST.
  - **COAST:** accumulators hold. An accepted sample updates the EMA, pulses `valid_out`, clears `miss_cnt` and returns to TRACK. On `frame_in` with no accepted sample, `miss_cnt++`; when `miss_cnt` reaches COAST_FRAMES, go to LOST.
- `valid_out` also pulses on the sample that completes acquisition. It never pulses in LOST, or in ACQUIRE before completion.
- `seen` flag: set by an accepted sample, cleared on `frame_in`.
- `valid_in` and `frame_in` in the same cycle: the sample belongs to the ending frame. The frame boundary is evaluated with `seen` = 1.
- `x_out` and `y_out` hold their last value in COAST and LOST, and are never cleared except by reset.

## Timing
- Reset (async assert, sync deassert by the top level): state LOST; `x_out`, `y_out`, `valid_out`, `tracking_out`, `state_out`, all counters and accumulators = 0.
- Latency: a sample at cycle N produces updated `x_out`/`y_out`, `valid_out`=1 and the new `state_out` at cycle N+1.
- `valid_out` is high for exactly one cycle.
- `frame_in` effects on state appear at N+1.
- A reset mid-frame discards all history; the next sample reseeds.
- There is no backpressure: the downstream stage must accept `valid_out` unconditionally.

## Configuration
- `CENTROID_JUMP_REJECT_EN` defined:
  - Per-axis absolute-difference comparators are compiled in.
  - Samples beyond `MAX_JUMP` in TRACK or COAST are treated as misses.
  - In ACQUIRE they cause a reseed.
- Undefined:
  - Comparators are absent and every `valid_in` is accepted.
  - `MAX_JUMP` is unused.

## Structure
- `centroid_track_pkg`:
  - `track_state_t` enum (2-bit, values above).
  - Coordinate width constants `X_W=11`, `Y_W=10`.
  - Counter width `CNT_W=4`.
- Sub-module `ema_axis` (parameters `W`, `F`):
  - Holds the accumulator, seed/update/hold control, and the output slice.
  - Optional jump comparator inside under the macro.
  - Instantiated once per axis.
  - The top level holds the FSM, counters and `seen` flag.

## Test plan
Defaults apply (ALPHA_SHIFT=2, ACQ_FRAMES=3, COAST_FRAMES=8, MAX_JUMP=64).

1. Reset, then samples (100,50), (100,50), (100,50) in three frames -> `valid_out` only after the third sample; `state_out`=2; out = (100,50).
2. In TRACK at out 100, sample x=120 -> next cycle `x_out`=105 (`acc` 400→420), single-cycle `valid_out`.
3. In TRACK, 8 frames with `frame_in` and no `valid_in` -> COAST after frame 1; LOST after frame 8; `tracking_out` drops; outputs hold the last value.
4. In COAST after 3 misses, sample (102,50) -> TRACK; `miss_cnt` cleared; `valid_out` pulse.
5. With `CENTROID_JUMP_REJECT_EN`, TRACK at x=100, sample x=300 -> no `valid_out`, counted as a miss, COAST at the next `frame_in`. Without the macro -> accepted, `x_out`=150.
6. `valid_in` and `frame_in` in the same cycle in TRACK -> remains TRACK; assert `rst_in` mid-ACQUIRE -> immediate LOST with all outputs 0.

Source files
------------

// File: rtl/centroid_track_pkg.sv
// Shared types and widths for the centroid tracker.
//   track_state_t : tracker state encoding (LOST=0, ACQUIRE=1, TRACK=2, COAST=3)
//   X_W / Y_W     : centroid coordinate widths
//   CNT_W         : width of the hit and miss frame counters
package centroid_track_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_LOST    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_COAST   = 2'd3
    } track_state_t;

endpackage

// File: rtl/centroid_tracker_ema_axis.sv
// ema_axis: one axis of the centroid smoother.
// Holds an unsigned W+F bit accumulator with F fractional bits, which is
// either seeded to the sample, moved 2^-F of the way towards it, or held.
// Optional macro: CENTROID_JUMP_REJECT_EN compiles in the |sample - pos|
// comparator; without it near_out is tied high.
// Ports:
//   clk_in     pixel clock
//   rst_in     asynchronous active-high reset (clears the accumulator)
//   sample_in  new coordinate
//   seed_in    load accumulator with sample_in << F
//   update_in  apply one EMA step towards sample_in
//   pos_out    accumulator >> F (truncated)
//   near_out   sample lies within MAX_JUMP of pos_out
module ema_axis #(
    parameter int W = 11,
    parameter int F = 2
`ifdef CENTROID_JUMP_REJECT_EN
    , parameter int MAX_JUMP = 64
`endif
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] sample_in,
    input  logic         seed_in,
    input  logic         update_in,
    output logic [W-1:0] pos_out,
    output logic         near_out
);

    localparam int AW = W + F;

    logic        [AW-1:0] acc;
    logic        [AW-1:0] target;
    logic signed [AW:0]   diff;
    logic signed [AW-1:0] step;

    assign target = AW'(sample_in) << F;
    assign diff   = $signed({1'b0, target}) - $signed({1'b0, acc});
    // The shifted difference always fits back into AW bits; adding it
    // modulo 2^AW gives the exact new accumulator.
    assign step   = AW'(diff >>> F);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc <= '0;
        end else if (seed_in) begin
            acc <= target;
        end else if (update_in) begin
            acc <= acc + $unsigned(step);
        end
    end

    assign pos_out = acc[AW-1:F];

`ifdef CENTROID_JUMP_REJECT_EN
    logic [W-1:0] dist;
    assign dist     = (sample_in >= pos_out) ? (sample_in - pos_out) : (pos_out - sample_in);
    assign near_out = (32'(dist) <= 32'(MAX_JUMP));
`else
    assign near_out = 1'b1;
`endif

endmodule

// File: rtl/centroid_tracker.sv
// centroid_tracker: temporal smoothing and gating of the per-frame centroid.
// EMA filter per axis (ema_axis), multi-frame acquisition, coasting across
// dropped frames. Optional macro CENTROID_JUMP_REJECT_EN enables per-axis
// jump rejection against MAX_JUMP.
// Ports:
//   clk_in        pixel clock
//   rst_in        asynchronous active-high reset (deassertion synchronised here)
//   x_in, y_in    centroid sample
//   valid_in      single-cycle sample strobe (at most one per frame)
//   frame_in      single-cycle end-of-frame pulse
//   x_out, y_out  filtered position (held in COAST/LOST)
//   valid_out     one-cycle strobe when the filtered position was updated
//   tracking_out  high in TRACK or COAST
//   state_out     current track_state_t encoding
module centroid_tracker
    import centroid_track_pkg::*;
#(
    parameter int ALPHA_SHIFT  = 2,
    parameter int ACQ_FRAMES   = 3,
    parameter int COAST_FRAMES = 8,
    parameter int MAX_JUMP     = 64
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic           valid_in,
    input  logic           frame_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           valid_out,
    output logic           tracking_out,
    output logic [1:0]     state_out
);

    if (ALPHA_SHIFT < 1 || ALPHA_SHIFT > 4) begin : g_bad_alpha
        $error("centroid_tracker: ALPHA_SHIFT out of range 1..4");
    end
    if (ACQ_FRAMES < 1 || ACQ_FRAMES > 15) begin : g_bad_acq
        $error("centroid_tracker: ACQ_FRAMES out of range 1..15");
    end
    if (COAST_FRAMES < 1 || COAST_FRAMES > 15) begin : g_bad_coast
        $error("centroid_tracker: COAST_FRAMES out of range 1..15");
    end
    if (MAX_JUMP < 0) begin : g_bad_jump
        $error("centroid_tracker: MAX_JUMP must be non-negative");
    end

    localparam logic [CNT_W-1:0] ACQ_N   = CNT_W'(ACQ_FRAMES);
    localparam logic [CNT_W-1:0] COAST_N = CNT_W'(COAST_FRAMES);

    // Reset asserts immediately, releases two clocks after rst_in falls.
    logic [1:0] rst_pipe;
    logic       rst;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rst_pipe <= '1;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end
    assign rst = rst_pipe[1];

    track_state_t     state;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] hit_nxt;
    logic [CNT_W-1:0] miss_nxt;
    logic             seen;
    logic             near_x;
    logic             near_y;
    logic             accept;
    logic             seed;
    logic             update;

    assign hit_nxt  = hit_cnt + 1'b1;
    assign miss_nxt = miss_cnt + 1'b1;

    // LOST takes every sample; elsewhere a sample must be near on both axes.
    // A rejected sample in ACQUIRE reseeds instead of updating.
    assign accept = valid_in && ((state == ST_LOST) || (near_x && near_y));
    assign seed   = valid_in && ((state == ST_LOST) || (state == ST_ACQUIRE && !accept));
    assign update = accept && (state != ST_LOST);

    ema_axis #(
        .W(X_W),
        .F(ALPHA_SHIFT)
`ifdef CENTROID_JUMP_REJECT_EN
        , .MAX_JUMP(MAX_JUMP)
`endif
    ) u_ema_x (
        .clk_in    (clk_in),
        .rst_in    (rst),
        .sample_in (x_in),
        .seed_in   (seed),
        .update_in (update),
        .pos_out   (x_out),
        .near_out  (near_x)
    );

    ema_axis #(
        .W(Y_W),
        .F(ALPHA_SHIFT)
`ifdef CENTROID_JUMP_REJECT_EN
        , .MAX_JUMP(MAX_JUMP)
`endif
    ) u_ema_y (
        .clk_in    (clk_in),
        .rst_in    (rst),
        .sample_in (y_in),
        .seed_in   (seed),
        .update_in (update),
        .pos_out   (y_out),
        .near_out  (near_y)
    );

    // A sample coinciding with frame_in belongs to the ending frame: every
    // frame check below tests !seen only when no sample was taken this cycle.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= ST_LOST;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            seen         <= 1'b0;
            valid_out    <= 1'b0;
            tracking_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            seen      <= frame_in ? 1'b0 : (seen | accept | seed);
            unique case (state)
                ST_LOST: begin
                    if (valid_in) begin
                        hit_cnt  <= CNT_W'(1);
                        miss_cnt <= '0;
                        if (ACQ_N == CNT_W'(1)) begin
                            state        <= ST_TRACK;
                            valid_out    <= 1'b1;
                            tracking_out <= 1'b1;
                        end else begin
                            state <= ST_ACQUIRE;
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (accept) begin
                        hit_cnt <= hit_nxt;
                        if (hit_nxt >= ACQ_N) begin
                            state        <= ST_TRACK;
                            valid_out    <= 1'b1;
                            tracking_out <= 1'b1;
                        end
                    end else if (valid_in) begin
                        hit_cnt <= CNT_W'(1);
                    end else if (frame_in && !seen) begin
                        state <= ST_LOST;
                    end
                end
                ST_TRACK: begin
                    if (accept) begin
                        valid_out <= 1'b1;
                        miss_cnt  <= '0;
                    end else if (frame_in && !seen) begin
                        miss_cnt <= CNT_W'(1);
                        state    <= ST_COAST;
                    end
                end
                ST_COAST: begin
                    if (accept) begin
                        valid_out <= 1'b1;
                        miss_cnt  <= '0;
                        state     <= ST_TRACK;
                    end else if (frame_in && !seen) begin
                        miss_cnt <= miss_nxt;
                        if (miss_nxt >= COAST_N) begin
                            state        <= ST_LOST;
                            tracking_out <= 1'b0;
                        end
                    end
                end
                default: state <= ST_LOST;
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed self-checking bench for centroid_tracker with default parameters.
// Expected values are hand-computed; jump-rejection expectations follow
// CENTROID_JUMP_REJECT_EN.
module tb_centroid_tracker;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic        frame_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tracking_out;
    logic [1:0]  state_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    centroid_tracker #(
        .ALPHA_SHIFT(2),
        .ACQ_FRAMES(3),
        .COAST_FRAMES(8),
        .MAX_JUMP(64)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .valid_in     (valid_in),
        .frame_in     (frame_in),
        .x_out        (x_out),
        .y_out        (y_out),
        .valid_out    (valid_out),
        .tracking_out (tracking_out),
        .state_out    (state_out)
    );

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic f, input logic [10:0] x, input logic [9:0] y);
        @(negedge clk_in);
        valid_in = v;
        frame_in = f;
        x_in     = x;
        y_in     = y;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        frame_in = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_out); end
        checks++; if (x_out !== 11'd0) begin errors++; $display("FAIL rst_x: got %0d expected 0", x_out); end
        checks++; if (y_out !== 10'd0) begin errors++; $display("FAIL rst_y: got %0d expected 0", y_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", valid_out); end
        checks++; if (tracking_out !== 1'b0) begin errors++; $display("FAIL rst_tracking: got %0b expected 0", tracking_out); end
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rst_release_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_acquire();
        drive(1'b1, 1'b0, 11'd100, 10'd50);
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL acq1_state: got %0d expected 1", state_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL acq1_valid: got %0b expected 0", valid_out); end
        checks++; if (x_out !== 11'd100) begin errors++; $display("FAIL acq1_x: got %0d expected 100", x_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL acq1_frame_state: got %0d expected 1", state_out); end
        drive(1'b1, 1'b0, 11'd100, 10'd50);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL acq2_valid: got %0b expected 0", valid_out); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL acq2_state: got %0d expected 1", state_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        drive(1'b1, 1'b0, 11'd100, 10'd50);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL acq3_valid: got %0b expected 1", valid_out); end
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL acq3_state: got %0d expected 2", state_out); end
        checks++; if (x_out !== 11'd100) begin errors++; $display("FAIL acq3_x: got %0d expected 100", x_out); end
        checks++; if (y_out !== 10'd50) begin errors++; $display("FAIL acq3_y: got %0d expected 50", y_out); end
        checks++; if (tracking_out !== 1'b1) begin errors++; $display("FAIL acq3_tracking: got %0b expected 1", tracking_out); end
        drive(1'b0, 1'b0, 11'd0, 10'd0);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL acq3_valid_width: got %0b expected 0", valid_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL acq3_frame_state: got %0d expected 2", state_out); end
    endtask

    // acc_x 400 -> 400 + (480-400)/4 = 420, x_out 105
    task automatic test_ema_step();
        drive(1'b1, 1'b0, 11'd120, 10'd50);
        checks++; if (x_out !== 11'd105) begin errors++; $display("FAIL ema_x: got %0d expected 105", x_out); end
        checks++; if (y_out !== 10'd50) begin errors++; $display("FAIL ema_y: got %0d expected 50", y_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL ema_valid: got %0b expected 1", valid_out); end
        drive(1'b0, 1'b0, 11'd0, 10'd0);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ema_valid_width: got %0b expected 0", valid_out); end
        checks++; if (x_out !== 11'd105) begin errors++; $display("FAIL ema_x_hold: got %0d expected 105", x_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL ema_frame_state: got %0d expected 2", state_out); end
    endtask

    // acc_x 420 -> 420 + floor((408-420)/4) = 417, x_out 104
    task automatic test_coast_recover();
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL coast_enter_state: got %0d expected 3", state_out); end
        checks++; if (tracking_out !== 1'b1) begin errors++; $display("FAIL coast_tracking: got %0b expected 1", tracking_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL coast3_state: got %0d expected 3", state_out); end
        checks++; if (x_out !== 11'd105) begin errors++; $display("FAIL coast3_x_hold: got %0d expected 105", x_out); end
        drive(1'b1, 1'b0, 11'd102, 10'd50);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL recover_state: got %0d expected 2", state_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL recover_valid: got %0b expected 1", valid_out); end
        checks++; if (x_out !== 11'd104) begin errors++; $display("FAIL recover_x: got %0d expected 104", x_out); end
        checks++; if (y_out !== 10'd50) begin errors++; $display("FAIL recover_y: got %0d expected 50", y_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL recover_frame_state: got %0d expected 2", state_out); end
    endtask

    task automatic test_coast_to_lost();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 11'd0, 10'd0);
            if (i == 1 || i == 7) begin
                checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL miss%0d_state: got %0d expected 3", i, state_out); end
            end
        end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL lost_state: got %0d expected 0", state_out); end
        checks++; if (tracking_out !== 1'b0) begin errors++; $display("FAIL lost_tracking: got %0b expected 0", tracking_out); end
        checks++; if (x_out !== 11'd104) begin errors++; $display("FAIL lost_x_hold: got %0d expected 104", x_out); end
        checks++; if (y_out !== 10'd50) begin errors++; $display("FAIL lost_y_hold: got %0d expected 50", y_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lost_valid: got %0b expected 0", valid_out); end
    endtask

    task automatic test_jump();
        drive(1'b1, 1'b0, 11'd100, 10'd50);
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        drive(1'b1, 1'b0, 11'd100, 10'd50);
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        drive(1'b1, 1'b0, 11'd100, 10'd50);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL jump_setup_state: got %0d expected 2", state_out); end
        drive(1'b1, 1'b0, 11'd300, 10'd50);
`ifdef CENTROID_JUMP_REJECT_EN
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL jump_valid: got %0b expected 0", valid_out); end
        checks++; if (x_out !== 11'd100) begin errors++; $display("FAIL jump_x: got %0d expected 100", x_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL jump_frame_state: got %0d expected 3", state_out); end
`else
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL jump_valid: got %0b expected 1", valid_out); end
        checks++; if (x_out !== 11'd150) begin errors++; $display("FAIL jump_x: got %0d expected 150", x_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL jump_frame_state: got %0d expected 2", state_out); end
`endif
    endtask

    // acc_x 800 -> 800 + (832-800)/4 = 808, x_out 202
    task automatic test_same_cycle();
        apply_reset();
        drive(1'b1, 1'b0, 11'd200, 10'd60);
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        drive(1'b1, 1'b0, 11'd200, 10'd60);
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        drive(1'b1, 1'b1, 11'd200, 10'd60);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL same_acq_state: got %0d expected 2", state_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL same_acq_valid: got %0b expected 1", valid_out); end
        checks++; if (y_out !== 10'd60) begin errors++; $display("FAIL same_acq_y: got %0d expected 60", y_out); end
        drive(1'b1, 1'b1, 11'd208, 10'd60);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL same_track_state: got %0d expected 2", state_out); end
        checks++; if (x_out !== 11'd202) begin errors++; $display("FAIL same_track_x: got %0d expected 202", x_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL same_track_valid: got %0b expected 1", valid_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL same_next_frame_state: got %0d expected 3", state_out); end
    endtask

    task automatic test_reset_mid_acquire();
        apply_reset();
        drive(1'b1, 1'b0, 11'd300, 10'd200);
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL mid_pre_state: got %0d expected 1", state_out); end
        checks++; if (x_out !== 11'd300) begin errors++; $display("FAIL mid_pre_x: got %0d expected 300", x_out); end
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d expected 0", state_out); end
        checks++; if (x_out !== 11'd0) begin errors++; $display("FAIL mid_rst_x: got %0d expected 0", x_out); end
        checks++; if (y_out !== 10'd0) begin errors++; $display("FAIL mid_rst_y: got %0d expected 0", y_out); end
        checks++; if (tracking_out !== 1'b0) begin errors++; $display("FAIL mid_rst_tracking: got %0b expected 0", tracking_out); end
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        drive(1'b1, 1'b0, 11'd10, 10'd20);
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL reseed_state: got %0d expected 1", state_out); end
        checks++; if (x_out !== 11'd10) begin errors++; $display("FAIL reseed_x: got %0d expected 10", x_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL acq_seen_frame_state: got %0d expected 1", state_out); end
        drive(1'b0, 1'b1, 11'd0, 10'd0);
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL acq_drop_state: got %0d expected 0", state_out); end
        checks++; if (x_out !== 11'd10) begin errors++; $display("FAIL acq_drop_x_hold: got %0d expected 10", x_out); end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_ema_step();
        test_coast_recover();
        test_coast_to_lost();
        test_jump();
        test_same_cycle();
        test_reset_mid_acquire();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
